priority_aging_controller: RTL and testbench
============================================

PRIORITY_AGING_CONTROLLER -- requirements
Module: priority_aging_controller

Interface
REQ-001 SHALL have parameter SIZE, default 4: number of requesters.
REQ-002 SHALL have parameter PRIORITY_WIDTH, default $clog2(SIZE): bits per priority level.
REQ-003 SHALL have parameter PRIORITIES_WIDTH, default PRIORITY_WIDTH*SIZE: packed priorities width.
REQ-004 SHALL have parameter AGE_THRESHOLD, default 4 (legal range 1 or more): waiting cycles per priority boost step.
REQ-005 SHALL have port clock, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port requests, input, SIZE: active requests, also forwarded to the downstream dynamic priority arbiter.
REQ-008 SHALL have port base_priorities, input, PRIORITIES_WIDTH: static per-requester priority; lane i is bits [i*PRIORITY_WIDTH +: PRIORITY_WIDTH].
REQ-009 SHALL have port grant, input, SIZE: one-hot or zero grant returned by the downstream arbiter.
REQ-010 SHALL have port effective_priorities, output, PRIORITIES_WIDTH: aged priorities driving the arbiter priorities input.
REQ-011 SHALL have port starving, output, SIZE: lane i high while its boost is saturated.

Function
REQ-012 Per lane i, SHALL hold a wait counter (0..AGE_THRESHOLD-1) and a boost register (PRIORITY_WIDTH bits).
REQ-013 Lane is "waiting" when requests[i]=1 and grant[i]=0; wait counter SHALL increment each waiting cycle.
REQ-014 On a waiting cycle with counter = AGE_THRESHOLD-1: counter SHALL wrap to 0 and boost SHALL increment, saturating at 2^PRIORITY_WIDTH-1.
REQ-015 At boost saturation, counter SHALL keep wrapping with no further boost change.
REQ-016 When grant[i]=1 or requests[i]=0, counter and boost SHALL both clear to 0 on the next edge; grant takes precedence over a simultaneous threshold crossing.
REQ-017 Grant on a lane with no request SHALL be tolerated: lane clears, no error.
REQ-018 effective_priorities lane i SHALL be combinational: min(base + boost, 2^PRIORITY_WIDTH-1), computed with one extra bit, no wrap-around.
REQ-019 Latency: base_priorities changes SHALL appear on effective_priorities same cycle; boost changes SHALL appear the cycle after the triggering edge.
REQ-020 starving[i] SHALL be registered-derived: boost[i] == 2^PRIORITY_WIDTH-1, regardless of base.
REQ-021 Lanes SHALL be fully independent; any number may age simultaneously.

Reset
REQ-022 While reset=1, all counters and boosts SHALL clear at the next edge; effective_priorities = base_priorities, starving = 0 from then on.
REQ-023 Reset asserted mid-aging SHALL discard all accumulated age; aging restarts from 0 on the first non-reset edge.
REQ-024 requests/grant SHALL be ignored on edges where reset=1.

Structure
REQ-025 No shared package; all widths derive from parameters, and the counter width SHALL be $clog2(AGE_THRESHOLD) with a minimum of 1 bit.
REQ-026 Per-lane logic SHALL be a sub-module priority_aging_slot (counter, boost, saturating add), instantiated SIZE times by generate.
REQ-027 Block SHALL be usable directly ahead of dynamic_priority_arbiter, with effective_priorities connected to its priorities input and its grant fed back.

Verification (SIZE=4, PRIORITY_WIDTH=2, AGE_THRESHOLD=4)
REQ-028 Scenario 1: requests=0001, base=0, grant=0 held -> lane0 effective 0,1,2,3 after 4, 8 and 12 edges respectively; starving[0]=1 from edge 12 and stays 3 thereafter.
REQ-029 Scenario 2: continuation of Scenario 1, then grant=0001 for one cycle -> next cycle lane0 effective=0, starving[0]=0, and aging restarts from 0.
REQ-030 Scenario 3: lane2 base=2, requested, never granted -> effective 3 after 4 edges, saturates at 3 (never 0); starving[2] asserts only after 12 edges.
REQ-031 Scenario 4: lane1 waits 3 cycles, grant on the 4th cycle (threshold crossing) -> boost stays 0, effective_priorities lane1 = base.
REQ-032 Scenario 5: lanes 0 and 3 age 10 cycles, reset pulsed one cycle, requests held -> after reset both effective = base, first boost 4 edges after reset deassertion.
REQ-033 Scenario 6: closed loop with dynamic_priority_arbiter, random requests/base for 1000 cycles -> no requester waits more than 12 + SIZE*AGE_THRESHOLD cycles unserved; grant always targets a highest-effective-priority request.

Source files
------------

// File: rtl/priority_aging_slot.sv
// priority_aging_slot: one requester lane of the aging controller.
// A lane that keeps requesting without being granted gains one priority step every
// AGE_THRESHOLD waiting cycles. The boost saturates at the top priority level and is
// added to the static base priority with saturation, never wrapping around.
module priority_aging_slot #(
    parameter int unsigned PRIORITY_WIDTH = 2,
    parameter int unsigned AGE_THRESHOLD  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      request,
    input  logic                      grant,
    input  logic [PRIORITY_WIDTH-1:0] base_priority,
    output logic [PRIORITY_WIDTH-1:0] effective_priority,
    output logic                      starving
);

    // A threshold of 1 still needs a 1-bit counter that sits at 0 and always wraps.
    localparam int unsigned COUNT_WIDTH =
        (AGE_THRESHOLD > 1) ? $clog2(AGE_THRESHOLD) : 1;
    localparam logic [COUNT_WIDTH-1:0]    COUNT_LAST   = COUNT_WIDTH'(AGE_THRESHOLD - 1);
    localparam logic [PRIORITY_WIDTH-1:0] PRIORITY_MAX = '1;

    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic [PRIORITY_WIDTH-1:0] boost_q, boost_d;
    logic                      waiting;
    logic [PRIORITY_WIDTH:0]   priority_sum;

    // Grant wins over a coincident threshold crossing because it removes the waiting state.
    assign waiting = request & ~grant;

    // Next-state for the wait counter and the saturating boost.
    always_comb begin
        count_d = count_q;
        boost_d = boost_q;
        if (!waiting) begin
            count_d = '0;
            boost_d = '0;
        end else if (count_q == COUNT_LAST) begin
            count_d = '0;
            if (boost_q != PRIORITY_MAX) begin
                boost_d = boost_q + PRIORITY_WIDTH'(1);
            end
        end else begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // Lane state; reset takes precedence over requests and grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            boost_q <= '0;
        end else begin
            count_q <= count_d;
            boost_q <= boost_d;
        end
    end

    // One extra carry bit detects overflow so the result clamps instead of wrapping.
    assign priority_sum       = {1'b0, base_priority} + {1'b0, boost_q};
    assign effective_priority = priority_sum[PRIORITY_WIDTH] ? PRIORITY_MAX
                                                             : priority_sum[PRIORITY_WIDTH-1:0];
    assign starving           = (boost_q == PRIORITY_MAX);

endmodule

// File: rtl/priority_aging_controller.sv
// priority_aging_controller: ages the static priorities of SIZE requesters so that a
// downstream dynamic priority arbiter cannot starve any of them. effective_priorities
// feeds the arbiter priorities input and the arbiter grant is fed back here.
module priority_aging_controller #(
    parameter int unsigned SIZE             = 4,
    parameter int unsigned PRIORITY_WIDTH   = $clog2(SIZE),
    parameter int unsigned PRIORITIES_WIDTH = PRIORITY_WIDTH * SIZE,
    parameter int unsigned AGE_THRESHOLD    = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [SIZE-1:0]             requests,
    input  logic [PRIORITIES_WIDTH-1:0] base_priorities,
    input  logic [SIZE-1:0]             grant,
    output logic [PRIORITIES_WIDTH-1:0] effective_priorities,
    output logic [SIZE-1:0]             starving
);

    // Lanes are fully independent; each owns its counter, boost and saturating adder.
    for (genvar i = 0; i < SIZE; i++) begin : g_slot
        priority_aging_slot #(
            .PRIORITY_WIDTH (PRIORITY_WIDTH),
            .AGE_THRESHOLD  (AGE_THRESHOLD)
        ) u_slot (
            .clock              (clock),
            .reset              (reset),
            .request            (requests[i]),
            .grant              (grant[i]),
            .base_priority      (base_priorities[i*PRIORITY_WIDTH +: PRIORITY_WIDTH]),
            .effective_priority (effective_priorities[i*PRIORITY_WIDTH +: PRIORITY_WIDTH]),
            .starving           (starving[i])
        );
    end

endmodule

// File: tb/tb_priority_aging_controller.sv
// tb_priority_aging_controller: vector table for the directed scenarios plus a
// closed-loop run against a round-robin tie-breaking priority arbiter model.
module tb_priority_aging_controller;

    localparam int SIZE = 4;
    localparam int PW   = 2;
    localparam int TH   = 4;
    localparam int MAX_WAIT = 12 + SIZE * TH;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] requests;
    logic [7:0] base_priorities;
    logic [3:0] grant;
    logic [7:0] effective_priorities;
    logic [3:0] starving;

    priority_aging_controller #(
        .SIZE          (SIZE),
        .AGE_THRESHOLD (TH)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .requests             (requests),
        .base_priorities      (base_priorities),
        .grant                (grant),
        .effective_priorities (effective_priorities),
        .starving             (starving)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] base;
        logic [3:0] gnt;
        logic [7:0] exp_eff;
        logic [3:0] exp_starv;
        string      tag;
    } vec_t;

    typedef struct {
        logic [7:0] eff;
        logic [3:0] starv;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state for the closed-loop run.
    int m_cnt[SIZE];
    int m_bst[SIZE];

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic add_vec(input logic rst, input logic [3:0] req, input logic [7:0] base,
                           input logic [3:0] gnt, input logic [7:0] e, input logic [3:0] s,
                           input string tag);
        vec_t v;
        v.rst = rst; v.req = req; v.base = base; v.gnt = gnt;
        v.exp_eff = e; v.exp_starv = s; v.tag = tag;
        vecs.push_back(v);
    endtask

    function automatic logic [1:0] sat(input int v);
        int c;
        c = (v > 3) ? 3 : v;
        return c[1:0];
    endfunction

    function automatic logic [7:0] model_eff(input logic [7:0] base);
        logic [7:0] r;
        int s;
        r = '0;
        for (int i = 0; i < SIZE; i++) begin
            s = int'(base[i*PW +: PW]) + m_bst[i];
            if (s > 3) s = 3;
            r[i*PW +: PW] = s[1:0];
        end
        return r;
    endfunction

    function automatic logic [3:0] model_starv();
        logic [3:0] r;
        for (int i = 0; i < SIZE; i++) r[i] = (m_bst[i] == 3);
        return r;
    endfunction

    task automatic model_step(input logic [3:0] req, input logic [3:0] gnt);
        for (int i = 0; i < SIZE; i++) begin
            if (!req[i] || gnt[i]) begin
                m_cnt[i] = 0;
                m_bst[i] = 0;
            end else if (m_cnt[i] == TH - 1) begin
                m_cnt[i] = 0;
                if (m_bst[i] < 3) m_bst[i]++;
            end else begin
                m_cnt[i]++;
            end
        end
    endtask

    // Apply one vector, push its expectation, and compare right after the edge.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        reset = v.rst; requests = v.req; base_priorities = v.base; grant = v.gnt;
        e.eff = v.exp_eff; e.starv = v.exp_starv; e.tag = v.tag;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check({e.tag, "_eff"}, idx, effective_priorities, e.eff);
        check({e.tag, "_starv"}, idx, {4'b0, starving}, {4'b0, e.starv});
    endtask

    initial begin
        logic [3:0] req_r, gnt_r;
        logic [7:0] base_r, e_now;
        int rr, max_wait, best, idx;
        int waits[SIZE];
        exp_t e;

        reset = 1'b1; requests = '0; base_priorities = '0; grant = '0;

        // Reset state: requests and grant are ignored while reset is high.
        add_vec(1'b1, 4'h0, 8'hE4, 4'h0, 8'hE4, 4'h0, "reset");
        add_vec(1'b1, 4'hF, 8'hE4, 4'h0, 8'hE4, 4'h0, "reset_req");
        add_vec(1'b1, 4'hF, 8'hE4, 4'hF, 8'hE4, 4'h0, "reset_gnt");
        // Lane 0 ages from base 0 to saturation.
        for (int k = 1; k <= 14; k++)
            add_vec(1'b0, 4'h1, 8'h00, 4'h0, {6'b0, sat(k / 4)}, {3'b0, k >= 12}, "s1_age");
        // Grant clears lane 0, then aging restarts from zero.
        add_vec(1'b0, 4'h1, 8'h00, 4'h1, 8'h00, 4'h0, "s2_grant");
        for (int k = 1; k <= 5; k++)
            add_vec(1'b0, 4'h1, 8'h00, 4'h0, {6'b0, sat(k / 4)}, 4'h0, "s2_restart");
        // Grant with no request is harmless.
        add_vec(1'b0, 4'h0, 8'hE4, 4'h8, 8'hE4, 4'h0, "gnt_noreq");
        // Lane 2 base 2 clamps at 3; starving only when boost itself saturates.
        for (int k = 1; k <= 14; k++)
            add_vec(1'b0, 4'h4, 8'h20, 4'h0, {2'b0, sat(2 + k / 4), 4'b0},
                    {1'b0, k >= 12, 2'b0}, "s3_clamp");
        // Lane 1: grant on the threshold-crossing cycle suppresses the boost.
        add_vec(1'b0, 4'h0, 8'h04, 4'h0, 8'h04, 4'h0, "s4_clear");
        for (int k = 1; k <= 3; k++)
            add_vec(1'b0, 4'h2, 8'h04, 4'h0, 8'h04, 4'h0, "s4_wait");
        add_vec(1'b0, 4'h2, 8'h04, 4'h2, 8'h04, 4'h0, "s4_grant");
        for (int k = 1; k <= 4; k++)
            add_vec(1'b0, 4'h2, 8'h04, 4'h0, {4'b0, sat(1 + k / 4), 2'b0}, 4'h0, "s4_after");
        // Lanes 0 and 3 age together, reset pulse discards all age.
        add_vec(1'b0, 4'h0, 8'h01, 4'h0, 8'h01, 4'h0, "s5_clear");
        for (int k = 1; k <= 10; k++)
            add_vec(1'b0, 4'h9, 8'h01, 4'h0, {sat(k / 4), 4'b0, sat(1 + k / 4)}, 4'h0,
                    "s5_age");
        add_vec(1'b1, 4'h9, 8'h01, 4'h0, 8'h01, 4'h0, "s5_reset");
        for (int k = 1; k <= 5; k++)
            add_vec(1'b0, 4'h9, 8'h01, 4'h0, {sat(k / 4), 4'b0, sat(1 + k / 4)}, 4'h0,
                    "s5_restart");

        @(negedge clock);
        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Closed loop: clear everything, then let an arbiter model drive grant.
        reset = 1'b1; requests = '0; grant = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            m_cnt[i] = 0; m_bst[i] = 0; waits[i] = 0;
        end
        req_r = '0; base_r = 8'($urandom); rr = 0; max_wait = 0;

        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (cyc % 50 == 0) base_r = 8'($urandom);
            requests = req_r; base_priorities = base_r; grant = '0;
            #1;
            // Base changes must show up combinationally in the same cycle.
            e_now = model_eff(base_r);
            check("loop_comb_eff", cyc, effective_priorities, e_now);

            // Highest effective priority wins; ties rotate round-robin.
            best = -1;
            for (int i = 0; i < SIZE; i++)
                if (req_r[i] && int'(effective_priorities[i*PW +: PW]) > best)
                    best = int'(effective_priorities[i*PW +: PW]);
            gnt_r = '0;
            for (int j = 0; j < SIZE; j++) begin
                idx = (rr + j) % SIZE;
                if (gnt_r == '0 && req_r[idx] && int'(effective_priorities[idx*PW +: PW]) == best)
                begin
                    gnt_r[idx] = 1'b1;
                    rr = (idx + 1) % SIZE;
                end
            end
            grant = gnt_r;

            model_step(req_r, gnt_r);
            e.eff = model_eff(base_r); e.starv = model_starv(); e.tag = "loop";
            sb.push_back(e);
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL loop_scoreboard step=%0d got=empty expected=entry", cyc);
            end else begin
                e = sb.pop_front();
                check("loop_eff", cyc, effective_priorities, e.eff);
                check("loop_starv", cyc, {4'b0, starving}, {4'b0, e.starv});
            end

            for (int i = 0; i < SIZE; i++) begin
                if (req_r[i] && !gnt_r[i]) begin
                    waits[i]++;
                    if (waits[i] > max_wait) max_wait = waits[i];
                end else begin
                    waits[i] = 0;
                end
                if (gnt_r[i]) begin
                    if ($urandom_range(1, 0) == 1) req_r[i] = 1'b0;
                end else if (!req_r[i]) begin
                    if ($urandom_range(1, 0) == 1) req_r[i] = 1'b1;
                end
            end
        end

        checks++;
        if (max_wait > MAX_WAIT) begin
            failures++;
            $display("FAIL loop_max_wait got=%0d expected<=%0d", max_wait, MAX_WAIT);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
